dma_rd_burst_ctrl: RTL
======================

# dma_rd_burst_ctrl

Read-side DMA burst controller for the systolic-array engine. It takes one large transfer request (base byte address, word count) and splits it into bursts of at most `MAX_BURST` words. Each burst is issued on the DMA read command port. The returned beat stream is written sequentially into an on-chip buffer. The block sits directly upstream of the DMA read engine, which it commands, and downstream of it, consuming its data.

## Interface
- `ADDR_W`, 32: DMA byte-address width.
- `DATA_W`, 32: data beat width; address stride per beat is `DATA_W/8` bytes.
- `LEN_W`, 16: width of the total word count.
- `MAX_BURST`, 16: maximum words per burst, legal range 1..255.
- `BUF_AW`, 10: buffer write-address width.
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: transfer request pulse; ignored while `busy`.
- `base_addr` in ADDR_W: transfer start byte address, sampled with `start`.
- `total_words` in LEN_W: words to transfer, sampled with `start`.
- `busy` out 1: transfer in progress.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: sticky beat-count error.
- `rd_start_dma` out 1: one-cycle burst command pulse.
- `rd_start_addr` out ADDR_W: burst byte address.
- `rd_num_trans` out 8: burst length in beats.
- `rd_done` in 1: DMA burst complete; coincides with the last beat.
- `rd_data` in DATA_W: beat data.
- `rd_data_vld` in 1: beat valid.
- `buf_we` out 1: buffer write enable.
- `buf_waddr` out BUF_AW: buffer word address.
- `buf_wdata` out DATA_W: buffer write data.

## Operation
- **States:** IDLE, ISSUE, WAIT, FIN.
- **IDLE**
  - `start` with `total_words`≠0: latch address and count, clear `buf_waddr` to 0, clear `err`, go to ISSUE.
  - `start` with `total_words`=0: no command is issued; `done` pulses the next cycle and the FSM stays in IDLE.
- **ISSUE**
  - Assert `rd_start_dma` for exactly one cycle.
  - `rd_start_addr` = current address.
  - `rd_num_trans` = min(remaining, `MAX_BURST`).
  - Go to WAIT.
- **WAIT**
  - Each `rd_data_vld` produces one buffer write.
  - On `rd_done`: remaining -= burst length and address += burst length × `DATA_W/8`, with ADDR_W wrap.
  - Then go to ISSUE if remaining≠0, otherwise go to FIN.
- **FIN:** one cycle, then IDLE.
- **Buffer addressing:** `buf_waddr` increments after every write and wraps modulo 2^BUF_AW.
- **Beats outside WAIT:** `rd_data_vld` in IDLE, ISSUE or FIN is dropped; no `buf_we` is generated.
- **Arithmetic:** remaining is LEN_W bits and never underflows, because the burst length is always ≤ remaining.

## Timing
- **Reset values:** all outputs are 0 (`busy`, `done`, `err`, `rd_start_dma`, `rd_start_addr`, `rd_num_trans`, `buf_we`, `buf_waddr`, `buf_wdata`). FSM is in IDLE.
- **Command latency:** `start` sampled at cycle 0 gives `rd_start_dma` high in cycle 1 and `busy` high from cycle 1.
- **Write latency:** `rd_data_vld` in cycle T gives `buf_we`/`buf_wdata`/`buf_waddr` registered in cycle T+1.
- **Between bursts:** `rd_done` in cycle T gives the next `rd_start_dma` in cycle T+2 (FSM is in ISSUE during T+1).
- **Completion:** the final `rd_done` in cycle T gives the last `buf_we` in T+1 and `done`=1 in T+2 for exactly one cycle; `busy` falls in T+2.
- **Zero-length request:** `start` at cycle 0 gives `done` in cycle 1; `busy` stays 0.
- **Reset mid-transfer:** all outputs return to their reset values the cycle after `rst`. Late beats from the aborted burst are dropped as IDLE beats.
- **Simultaneous `start` and `done`:** `start` is accepted only in IDLE, so a `start` in the `done` cycle is accepted.

## Configuration
- `DMA_RD_BEAT_CHK_EN` defined:
  - A per-burst beat counter is compared with `rd_num_trans` when `rd_done` arrives (the coincident beat counts).
  - A mismatch, or any beat past the burst length, sets `err`.
  - `err` stays set until `rst` or the next accepted `start`.
- `DMA_RD_BEAT_CHK_EN` undefined: the counter is absent, `err` is tied to 0, and the transfer proceeds on `rd_done` alone.

## Structure
- Shared package `dma_rd_pkg` holds:
  - the state enum;
  - the default `MAX_BURST`;
  - a bytes-per-beat constant function of `DATA_W`.
- Single module, no sub-modules.
- Bench instantiates `dma_read_stub` as the DMA model.

## Test plan
- **Multi-burst transfer:** `base_addr`=0x1000, `total_words`=40, `MAX_BURST`=16.
  - Expect exactly three commands, in order: (0x1000,16), (0x1040,16), (0x1080,8).
  - Expect 40 writes at `buf_waddr` 0..39, with data 0x1000..0x100F, 0x1040..0x104F, 0x1080..0x1087.
  - Expect one `done` pulse, in the cycle after the last `buf_we`.
- **Zero-length request:** `total_words`=0 → no `rd_start_dma`, `done` in the cycle after `start`, `busy` never high.
- **Exact single burst:** `total_words`=16 → one command (base,16), 16 writes, `done` two cycles after `rd_done`.
- **Buffer wrap:** `BUF_AW`=4, `total_words`=20 → write addresses 0..15 then 0..3.
- **Reset mid-burst:** `rst` after 5 beats of a 16-beat burst → all outputs 0 the next cycle, no further `buf_we`; a new `start` then completes normally.
- **Beat-count check:** `DMA_RD_BEAT_CHK_EN` set, and the DMA model is forced to assert `rd_done` after 3 of 16 beats.
  - Expect `err`=1 and sticky.
  - With the macro undefined, `err` stays 0.

Source files
------------

// File: rtl/dma_rd_pkg.sv
// -----------------------------------------------------------------------------
// dma_rd_pkg
// Shared definitions for the read-side DMA burst controller:
//   - state_e        : controller FSM states
//   - DEF_MAX_BURST  : default maximum words per burst
//   - bytes_per_beat : byte stride of one data beat for a given data width
// -----------------------------------------------------------------------------
package dma_rd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_FIN   = 2'd3
    } state_e;

    localparam int DEF_MAX_BURST = 16;

    function automatic int bytes_per_beat(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/dma_rd_burst_ctrl_if.sv
// -----------------------------------------------------------------------------
// dma_rd_burst_ctrl_if
// Bundles the request, DMA read command/data and buffer write signals of the
// burst controller.
//   master : the burst controller (drives status, DMA command, buffer write)
//   slave  : the environment (drives request and DMA return data)
// Signals:
//   start, base_addr, total_words    transfer request
//   busy, done, err                  transfer status
//   rd_start_dma, rd_start_addr,
//   rd_num_trans                     DMA burst command
//   rd_done, rd_data, rd_data_vld    DMA return beats
//   buf_we, buf_waddr, buf_wdata     on-chip buffer write port
// -----------------------------------------------------------------------------
interface dma_rd_burst_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 16,
    parameter int BUF_AW = 10
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [LEN_W-1:0]  total_words;
    logic              busy;
    logic              done;
    logic              err;
    logic              rd_start_dma;
    logic [ADDR_W-1:0] rd_start_addr;
    logic [7:0]        rd_num_trans;
    logic              rd_done;
    logic [DATA_W-1:0] rd_data;
    logic              rd_data_vld;
    logic              buf_we;
    logic [BUF_AW-1:0] buf_waddr;
    logic [DATA_W-1:0] buf_wdata;

    modport master (
        input  start, base_addr, total_words,
        input  rd_done, rd_data, rd_data_vld,
        output busy, done, err,
        output rd_start_dma, rd_start_addr, rd_num_trans,
        output buf_we, buf_waddr, buf_wdata
    );

    modport slave (
        output start, base_addr, total_words,
        output rd_done, rd_data, rd_data_vld,
        input  busy, done, err,
        input  rd_start_dma, rd_start_addr, rd_num_trans,
        input  buf_we, buf_waddr, buf_wdata
    );

endinterface

// File: rtl/dma_rd_burst_ctrl.sv
// -----------------------------------------------------------------------------
// dma_rd_burst_ctrl
// Splits one (base byte address, word count) read request into DMA bursts of
// at most MAX_BURST words, issues them one at a time and writes the returned
// beats sequentially into an on-chip buffer.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : dma_rd_burst_ctrl_if.master (request, status, DMA command/data,
//          buffer write)
// Optional feature (macro DMA_RD_BEAT_CHK_EN): per-burst beat counter that
// sets the sticky err flag on a beat-count mismatch; without it err is 0.
// -----------------------------------------------------------------------------
module dma_rd_burst_ctrl
    import dma_rd_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int LEN_W     = 16,
    parameter int MAX_BURST = DEF_MAX_BURST,
    parameter int BUF_AW    = 10
) (
    input  logic                clk,
    input  logic                rst,
    dma_rd_burst_ctrl_if.master bus
);

    localparam int               BPB     = bytes_per_beat(DATA_W);
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BURST);
    localparam logic [7:0]       MAX_B8  = 8'(MAX_BURST);

    // min(words, MAX_BURST); fits 8 bits because MAX_BURST <= 255
    function automatic logic [7:0] burst_len(input logic [LEN_W-1:0] words);
        if (words < MAX_LEN) begin
            return words[7:0];
        end else begin
            return MAX_B8;
        end
    endfunction

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  remain_q, remain_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              cmd_q, cmd_d;
    logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
    logic [7:0]        cmd_len_q, cmd_len_d;
    logic              we_q, we_d;
    logic [BUF_AW-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [BUF_AW-1:0] wptr_q, wptr_d;

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            remain_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cmd_q      <= 1'b0;
            cmd_addr_q <= '0;
            cmd_len_q  <= 8'd0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            wptr_q     <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            remain_q   <= remain_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            cmd_q      <= cmd_d;
            cmd_addr_q <= cmd_addr_d;
            cmd_len_q  <= cmd_len_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            wptr_q     <= wptr_d;
        end
    end

    // Next-state and next-output logic of the burst FSM
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        remain_d   = remain_q;
        done_d     = 1'b0;
        cmd_d      = 1'b0;
        cmd_addr_d = cmd_addr_q;
        cmd_len_d  = cmd_len_q;
        we_d       = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        wptr_d     = wptr_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start && (bus.total_words != '0)) begin
                    // The first burst is commanded straight from the request
                    // so rd_start_dma follows start by one cycle; ISSUE is
                    // only traversed between bursts.
                    addr_d     = bus.base_addr;
                    remain_d   = bus.total_words;
                    cmd_d      = 1'b1;
                    cmd_addr_d = bus.base_addr;
                    cmd_len_d  = burst_len(bus.total_words);
                    waddr_d    = '0;
                    wptr_d     = '0;
                    state_d    = ST_WAIT;
                end else if (bus.start) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                cmd_d      = 1'b1;
                cmd_addr_d = addr_q;
                cmd_len_d  = burst_len(remain_q);
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.rd_data_vld) begin
                    we_d    = 1'b1;
                    waddr_d = wptr_q;
                    wdata_d = bus.rd_data;
                    wptr_d  = wptr_q + {{(BUF_AW-1){1'b0}}, 1'b1};
                end else begin
                    we_d = 1'b0;
                end
                if (bus.rd_done) begin
                    // burst length never exceeds remain_q, so no underflow
                    remain_d = remain_q - LEN_W'(cmd_len_q);
                    addr_d   = addr_q + (ADDR_W'(cmd_len_q) * ADDR_W'(BPB));
                    state_d  = (remain_d != '0) ? ST_ISSUE : ST_FIN;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_FIN: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // busy is registered from the next state so it rises with the first command
    assign busy_d = (state_d != ST_IDLE);

`ifdef DMA_RD_BEAT_CHK_EN
    logic [8:0] beat_cnt_q, beat_cnt_d;
    logic [8:0] beats_s;
    logic       err_q, err_d;

    // Beat counter register and sticky error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt_q <= 9'd0;
            err_q      <= 1'b0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
            err_q      <= err_d;
        end
    end

    // Count beats of the current burst and compare against its length
    always_comb begin
        beat_cnt_d = beat_cnt_q;
        err_d      = err_q;
        beats_s    = beat_cnt_q + {8'd0, bus.rd_data_vld};
        if ((state_q == ST_IDLE) && bus.start) begin
            beat_cnt_d = 9'd0;
            err_d      = 1'b0;
        end else if (state_q == ST_WAIT) begin
            // a beat beyond the burst length, or a final count (including the
            // beat coincident with rd_done) that differs from the length
            err_d = err_q
                  | (bus.rd_data_vld & (beat_cnt_q >= {1'b0, cmd_len_q}))
                  | (bus.rd_done & (beats_s != {1'b0, cmd_len_q}));
            if (bus.rd_done) begin
                beat_cnt_d = 9'd0;
            end else begin
                beat_cnt_d = beats_s;
            end
        end else begin
            beat_cnt_d = 9'd0;
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.rd_start_dma  = cmd_q;
    assign bus.rd_start_addr = cmd_addr_q;
    assign bus.rd_num_trans  = cmd_len_q;
    assign bus.buf_we        = we_q;
    assign bus.buf_waddr     = waddr_q;
    assign bus.buf_wdata     = wdata_q;

endmodule
